// File: rtl/sw_pkg.sv
// Shared definitions for the BCD stopwatch: state encoding, digit geometry,
// the default prescaler ratio and a small BCD helper.
package sw_pkg;

  localparam int unsigned DIGIT_W          = 4;
  localparam int unsigned NUM_DIGITS       = 4;
  // 40 MHz system clock divided down to a 100 Hz (0.01 s) tick.
  localparam int unsigned TICK_DIV_DEFAULT = 400000;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } sw_state_e;

  // True when a digit is about to roll over on its next increment.
  function automatic logic is_bcd_max(input logic [DIGIT_W-1:0] q);
    return q == BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the stopwatch cascade: a 0..9 counter.
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset, q returns to 0
//   en      - increment request (tick or carry from the lower digit)
//   clr     - synchronous clear, takes priority over en
//   q       - registered BCD value, always 0..9
//   carry_c - combinational carry to the next digit, en & (q == 9)
module bcd_digit
  import sw_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               carry_c
);

  // Carry is combinational so the whole chain settles within one cycle
  // and every digit updates on the same edge.
  assign carry_c = en & is_bcd_max(q);

  // Decade counter with wrap 9 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= is_bcd_max(q) ? '0 : q + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch, 00.00 .. 99.99 s in 0.01 s steps, feeding the
// segment7 display driver directly.
// Ports:
//   CLK      - system clock (40 MHz), rising edge
//   IN_CLR   - asynchronous active-low reset
//   BTN_SS   - start/stop button, asynchronous level, active-high
//   BTN_CLR  - clear button, asynchronous level, active-high
//   D1..D4   - registered BCD digits, D1 = 0.01 s ... D4 = 10 s
//   RUNNING  - registered, high while counting
//   OVF      - registered sticky flag, set on the 99.99 -> 00.00 wrap
module bcd_stopwatch
  import sw_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic               CLK,
  input  logic               IN_CLR,
  input  logic               BTN_SS,
  input  logic               BTN_CLR,
  output logic [DIGIT_W-1:0] D1,
  output logic [DIGIT_W-1:0] D2,
  output logic [DIGIT_W-1:0] D3,
  output logic [DIGIT_W-1:0] D4,
  output logic               RUNNING,
  output logic               OVF
);

  localparam int unsigned       PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);

  sw_state_e state;

  // ---------------------------------------------------------------------
  // Button conditioning: two-flop synchronizer plus rising-edge detector.
  // A press reaches the FSM on the third rising edge after it goes high;
  // holding the button yields a single pulse.
  // ---------------------------------------------------------------------
  logic [1:0] ss_sync;
  logic       ss_prev;
  logic       ss_pulse_c;

  always_ff @(posedge CLK or negedge IN_CLR) begin
    if (!IN_CLR) begin
      ss_sync <= '0;
      ss_prev <= 1'b0;
    end else begin
      ss_sync <= {ss_sync[0], BTN_SS};
      ss_prev <= ss_sync[1];
    end
  end

  assign ss_pulse_c = ss_sync[1] & ~ss_prev;

  logic [1:0] clr_sync;
  logic       clr_prev;
  logic       clr_pulse_c;

  always_ff @(posedge CLK or negedge IN_CLR) begin
    if (!IN_CLR) begin
      clr_sync <= '0;
      clr_prev <= 1'b0;
    end else begin
      clr_sync <= {clr_sync[0], BTN_CLR};
      clr_prev <= clr_sync[1];
    end
  end

  assign clr_pulse_c = clr_sync[1] & ~clr_prev;

  // ---------------------------------------------------------------------
  // Control FSM. In STOP a simultaneous clear beats start/stop; in IDLE
  // start wins; in RUN clear is simply ignored.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge IN_CLR) begin
    if (!IN_CLR) begin
      state   <= IDLE;
      RUNNING <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ss_pulse_c) begin
            state   <= RUN;
            RUNNING <= 1'b1;
          end
        end
        RUN: begin
          if (ss_pulse_c) begin
            state   <= STOP;
            RUNNING <= 1'b0;
          end
        end
        STOP: begin
          if (clr_pulse_c) begin
            state   <= IDLE;
            RUNNING <= 1'b0;
          end else if (ss_pulse_c) begin
            state   <= RUN;
            RUNNING <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          RUNNING <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Prescaler: runs only while in RUN and is zeroed whenever RUN is left,
  // so each entry to RUN starts a fresh 0.01 s interval.
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0] presc;
  logic             tick_c;

  assign tick_c = (state == RUN) && (presc == PRE_LAST);

  always_ff @(posedge CLK or negedge IN_CLR) begin
    if (!IN_CLR) begin
      presc <= '0;
    end else if ((state == RUN) && !ss_pulse_c) begin
      presc <= tick_c ? '0 : presc + PRE_W'(1);
    end else begin
      presc <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // Digit cascade. Carries ripple combinationally, so a full rollover
  // such as 09.99 -> 10.00 lands on a single edge.
  // ---------------------------------------------------------------------
  logic [NUM_DIGITS:0] carry_chain;
  logic [DIGIT_W-1:0]  digit_q [NUM_DIGITS];
  logic                clr_digits_c;

  assign carry_chain[0] = tick_c;
  // Clear only takes effect while stopped; the prescaler is idle then, so
  // clear and increment never collide.
  assign clr_digits_c   = (state == STOP) && clr_pulse_c;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk     (CLK),
      .rst_n   (IN_CLR),
      .en      (carry_chain[i]),
      .clr     (clr_digits_c),
      .q       (digit_q[i]),
      .carry_c (carry_chain[i+1])
    );
  end

  assign D1 = digit_q[0];
  assign D2 = digit_q[1];
  assign D3 = digit_q[2];
  assign D4 = digit_q[3];

  // ---------------------------------------------------------------------
  // Overflow flag: set by the carry out of the top digit, cleared by an
  // accepted clear (STOP, or IDLE when start is not pressed with it).
  // ---------------------------------------------------------------------
  logic ovf_clr_c;

  assign ovf_clr_c = clr_pulse_c &&
                     ((state == STOP) || ((state == IDLE) && !ss_pulse_c));

  always_ff @(posedge CLK or negedge IN_CLR) begin
    if (!IN_CLR) begin
      OVF <= 1'b0;
    end else if (ovf_clr_c) begin
      OVF <= 1'b0;
    end else if (carry_chain[NUM_DIGITS]) begin
      OVF <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch (TICK_DIV = 4, 25 ns clock).
// A behavioural model keeps the elapsed time as an integer count of
// hundredths and derives the expected digits arithmetically.
`timescale 1ns/100ps
module tb_bcd_stopwatch;

  localparam int TICK_DIV = 4;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_STOP   = 2;

  logic       CLK     = 1'b0;
  logic       IN_CLR  = 1'b1;
  logic       BTN_SS  = 1'b0;
  logic       BTN_CLR = 1'b0;
  logic [3:0] D1, D2, D3, D4;
  logic       RUNNING, OVF;

  bcd_stopwatch #(.TICK_DIV(TICK_DIV)) dut (
    .CLK     (CLK),
    .IN_CLR  (IN_CLR),
    .BTN_SS  (BTN_SS),
    .BTN_CLR (BTN_CLR),
    .D1      (D1),
    .D2      (D2),
    .D3      (D3),
    .D4      (D4),
    .RUNNING (RUNNING),
    .OVF     (OVF)
  );

  always #12.5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int         m_state;
  int         m_cs;          // elapsed hundredths, 0..9999
  int         m_run_cycles;  // edges spent in RUN since last entry
  logic       m_ovf;
  logic [2:0] ss_hist;       // [0] = button level at the latest edge
  logic [2:0] clr_hist;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {14'd0, D4, D3, D2, D1, RUNNING, OVF};
  endfunction

  function automatic logic [31:0] dut_digits();
    return {16'd0, D4, D3, D2, D1};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {14'd0, to_bcd(m_cs), (m_state == M_RUN), m_ovf};
  endfunction

  task automatic model_reset();
    m_state      = M_IDLE;
    m_cs         = 0;
    m_run_cycles = 0;
    m_ovf        = 1'b0;
    ss_hist      = '0;
    clr_hist     = '0;
  endtask

  // One rising edge of behaviour: a press counts on the third edge after
  // the button is seen high following a low sample.
  task automatic model_step();
    logic ss_p, clr_p;
    if (!IN_CLR) begin
      model_reset();
      return;
    end
    ss_p     = ss_hist[1] & ~ss_hist[2];
    clr_p    = clr_hist[1] & ~clr_hist[2];
    ss_hist  = {ss_hist[1:0], BTN_SS};
    clr_hist = {clr_hist[1:0], BTN_CLR};
    if (m_state == M_RUN) begin
      m_run_cycles++;
      if (m_run_cycles % TICK_DIV == 0) begin
        m_cs = (m_cs + 1) % 10000;
        if (m_cs == 0) m_ovf = 1'b1;
      end
    end
    case (m_state)
      M_IDLE: begin
        if (ss_p) begin
          m_state      = M_RUN;
          m_run_cycles = 0;
        end else if (clr_p) begin
          m_ovf = 1'b0;
        end
      end
      M_RUN: begin
        if (ss_p) m_state = M_STOP;
      end
      default: begin
        if (clr_p) begin
          m_state = M_IDLE;
          m_cs    = 0;
          m_ovf   = 1'b0;
        end else if (ss_p) begin
          m_state      = M_RUN;
          m_run_cycles = 0;
        end
      end
    endcase
  endtask

  // Advance one clock, update the model on the edge, compare on the
  // falling edge. Inputs are only changed after this returns.
  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check("cycle", dut_vec(), exp_vec());
  endtask

  task automatic press(input logic ss, input logic clr, input int hold);
    BTN_SS  = ss;
    BTN_CLR = clr;
    repeat (hold) cycle();
    BTN_SS  = 1'b0;
    BTN_CLR = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n = 0;
    while (m_cs != target && n < budget) begin
      cycle();
      n++;
    end
    check(tag, dut_digits(), 32'(to_bcd(target)));
  endtask

  initial begin
    model_reset();
    #2 IN_CLR = 1'b0;
    repeat (3) cycle();
    check("reset_state", dut_vec(), 32'h0);
    IN_CLR = 1'b1;
    repeat (20) cycle();
    check("idle_state", dut_vec(), 32'h0);

    // Start latency and first ticks.
    BTN_SS = 1'b1;
    repeat (2) cycle();
    check("start_edge2", 32'(RUNNING), 32'd0);
    cycle();
    check("start_edge3", 32'(RUNNING), 32'd1);
    repeat (3) cycle();
    check("tick1_early", 32'(D1), 32'd0);
    cycle();
    check("tick1", 32'(D1), 32'd1);
    repeat (4) cycle();
    check("tick2", 32'(D1), 32'd2);
    BTN_SS = 1'b0;

    // Stop at 00.40 and hold.
    run_until(40, 400, "reach_0040");
    BTN_SS = 1'b1;
    repeat (4) cycle();
    BTN_SS = 1'b0;
    repeat (100) cycle();
    check("stop_hold", dut_digits(), 32'h0040);
    check("stop_running", 32'(RUNNING), 32'd0);

    // Resume: next increment four cycles after RUNNING rises.
    BTN_SS = 1'b1;
    repeat (3) cycle();
    check("resume_edge3", 32'(RUNNING), 32'd1);
    repeat (3) cycle();
    check("resume_hold", dut_digits(), 32'h0040);
    cycle();
    check("resume_tick", dut_digits(), 32'h0041);
    repeat (4) cycle();
    BTN_SS = 1'b0;

    // Clear while running is ignored.
    press(1'b0, 1'b1, 4);
    check("clr_in_run", 32'(RUNNING), 32'd1);

    // Cascade 09.99 -> 10.00, then wrap.
    run_until(999, 5000, "reach_0999");
    run_until(1000, 8, "cascade_1000");
    begin : wrap_wait
      int n = 0;
      while (!m_ovf && n < 40000) begin
        cycle();
        n++;
      end
    end
    check("wrap", dut_vec(), 32'h3);

    // Stop, clear -> IDLE with OVF cleared.
    press(1'b1, 1'b0, 4);
    check("stop_after_wrap", 32'(RUNNING), 32'd0);
    press(1'b0, 1'b1, 4);
    check("clear_stop", dut_vec(), 32'h0);

    // Simultaneous ss+clr in STOP -> IDLE.
    press(1'b1, 1'b0, 4);
    repeat (20) cycle();
    press(1'b1, 1'b0, 4);
    check("stop2", 32'(RUNNING), 32'd0);
    press(1'b1, 1'b1, 4);
    check("ss_clr_stop", dut_vec(), 32'h0);

    // Simultaneous ss+clr in IDLE -> RUN.
    press(1'b1, 1'b1, 4);
    check("ss_clr_idle", 32'(RUNNING), 32'd1);

    // Async reset mid-run at 37.25, button held through release.
    run_until(3725, 16000, "reach_3725");
    #3 IN_CLR = 1'b0;
    #1 check("async_reset", dut_vec(), 32'h0);
    model_reset();
    BTN_SS = 1'b1;
    repeat (2) cycle();
    IN_CLR = 1'b1;
    repeat (2) cycle();
    check("rel_edge2", 32'(RUNNING), 32'd0);
    cycle();
    check("rel_edge3", 32'(RUNNING), 32'd1);
    repeat (20) cycle();
    check("one_pulse", 32'(RUNNING), 32'd1);
    BTN_SS = 1'b0;

    // Random button activity against the model.
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) BTN_SS = ~BTN_SS;
      if ($urandom_range(0, 39) == 0) BTN_CLR = ~BTN_CLR;
      cycle();
    end
    BTN_SS  = 1'b0;
    BTN_CLR = 1'b0;
    repeat (5) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
